video_dram_arb: RTL and testbench

VIDEO_DRAM_ARB -- requirements
Module: video_dram_arb

---
 rtl/video_dram_arb.sv | 142 ++++++++++++++
 tb/tb_video_dram_arb.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_dram_arb.sv
// video_dram_arb: per-slot DRAM arbiter for video, tilemap, TS renderer and Z80.
// Requests are sampled on the c3 slot strobe. The winner owns the next 4-clock
// slot: *_pre_next pulses the cycle after the decision, and *_next pulses on
// the c3 that ends the slot, which is also the cycle the next owner is chosen.
// Ports:
//   clk, res_n (async active-low), c3 (slot strobe)
//   video_go/video_addr, tm_req/tm_addr, ts_req/ts_addr, cpu_req/cpu_addr
//   ts_z80_lp      : 1 = cpu ranks below ts, 0 = cpu ranks above ts
//   dram_req/dram_addr : slot active flag and granted address (registered)
//   *_pre_next     : grant-accepted pulse (registered)
//   *_next         : data-valid pulse, decoded from slot owner and c3
//   owner          : 0 idle, 1 video, 2 tm, 3 ts, 4 cpu
// Optional feature: define VIDEO_TS_STARVE_GUARD_EN to let ts win over tm/cpu
// after 7 consecutive lost decisions.
module video_dram_arb #(
  localparam int unsigned AW = 21
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          c3,
  input  logic          video_go,
  input  logic [AW-1:0] video_addr,
  input  logic          tm_req,
  input  logic [AW-1:0] tm_addr,
  input  logic          ts_req,
  input  logic [AW-1:0] ts_addr,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic          ts_z80_lp,
  output logic          dram_req,
  output logic [AW-1:0] dram_addr,
  output logic          video_pre_next,
  output logic          tm_pre_next,
  output logic          ts_pre_next,
  output logic          cpu_pre_next,
  output logic          video_next,
  output logic          tm_next,
  output logic          ts_next,
  output logic          cpu_next,
  output logic [2:0]    owner
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    VID  = 3'd1,
    TM   = 3'd2,
    TS   = 3'd3,
    CPU  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          req_d;
  logic [AW-1:0] addr_d;
  logic [3:0]    pre_d;  // {video, tm, ts, cpu}

`ifdef VIDEO_TS_STARVE_GUARD_EN
  logic [2:0] starve_q, starve_d;
`endif

  // State, address and grant-pulse registers
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q   <= IDLE;
      dram_req  <= 1'b0;
      dram_addr <= '0;
      {video_pre_next, tm_pre_next, ts_pre_next, cpu_pre_next} <= 4'b0000;
`ifdef VIDEO_TS_STARVE_GUARD_EN
      starve_q  <= 3'd0;
`endif
    end else begin
      state_q   <= state_d;
      dram_req  <= req_d;
      dram_addr <= addr_d;
      {video_pre_next, tm_pre_next, ts_pre_next, cpu_pre_next} <= pre_d;
`ifdef VIDEO_TS_STARVE_GUARD_EN
      starve_q  <= starve_d;
`endif
    end
  end

  // Slot decision: everything holds between strobes, re-arbitrates on c3
  always_comb begin
    state_d = state_q;
    req_d   = dram_req;
    addr_d  = dram_addr;
    pre_d   = 4'b0000;
`ifdef VIDEO_TS_STARVE_GUARD_EN
    starve_d = starve_q;
`endif
    if (c3) begin
      state_d = IDLE;
      addr_d  = '0;
      if (video_go) begin
        state_d = VID;
        addr_d  = video_addr;
`ifdef VIDEO_TS_STARVE_GUARD_EN
      end else if (ts_req && (starve_q == 3'd7)) begin
        state_d = TS;
        addr_d  = ts_addr;
`endif
      end else if (tm_req) begin
        state_d = TM;
        addr_d  = tm_addr;
      end else if (cpu_req && !ts_z80_lp) begin
        state_d = CPU;
        addr_d  = cpu_addr;
      end else if (ts_req) begin
        state_d = TS;
        addr_d  = ts_addr;
      end else if (cpu_req) begin
        state_d = CPU;
        addr_d  = cpu_addr;
      end
      req_d = (state_d != IDLE);
      case (state_d)
        VID:     pre_d = 4'b1000;
        TM:      pre_d = 4'b0100;
        TS:      pre_d = 4'b0010;
        CPU:     pre_d = 4'b0001;
        default: pre_d = 4'b0000;
      endcase
`ifdef VIDEO_TS_STARVE_GUARD_EN
      // Count consecutive decisions where ts asked and lost; saturate at 7
      if (!ts_req || (state_d == TS)) begin
        starve_d = 3'd0;
      end else if (starve_q != 3'd7) begin
        starve_d = starve_q + 3'd1;
      end
`endif
    end
  end

  // Data-valid lands on the strobe that closes the owned slot; reset clears
  // the owner immediately so an abandoned slot never signals completion.
  assign video_next = c3 && (state_q == VID);
  assign tm_next    = c3 && (state_q == TM);
  assign ts_next    = c3 && (state_q == TS);
  assign cpu_next   = c3 && (state_q == CPU);

  assign owner = 3'(state_q);

endmodule

// File: tb/tb_video_dram_arb.sv
// Testbench for video_dram_arb: fixed vector table, hand-written slot
// sequences and randomized traffic, all checked against a cycle model.
module tb_video_dram_arb;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        c3 = 1'b0;
  logic        video_go = 1'b0, tm_req = 1'b0, ts_req = 1'b0, cpu_req = 1'b0;
  logic        ts_z80_lp = 1'b0;
  logic [20:0] video_addr = '0, tm_addr = '0, ts_addr = '0, cpu_addr = '0;
  logic        dram_req;
  logic [20:0] dram_addr;
  logic        video_pre_next, tm_pre_next, ts_pre_next, cpu_pre_next;
  logic        video_next, tm_next, ts_next, cpu_next;
  logic [2:0]  owner;

  video_dram_arb dut (
    .clk(clk), .res_n(res_n), .c3(c3),
    .video_go(video_go), .video_addr(video_addr),
    .tm_req(tm_req), .tm_addr(tm_addr),
    .ts_req(ts_req), .ts_addr(ts_addr),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .ts_z80_lp(ts_z80_lp),
    .dram_req(dram_req), .dram_addr(dram_addr),
    .video_pre_next(video_pre_next), .tm_pre_next(tm_pre_next),
    .ts_pre_next(ts_pre_next), .cpu_pre_next(cpu_pre_next),
    .video_next(video_next), .tm_next(tm_next),
    .ts_next(ts_next), .cpu_next(cpu_next),
    .owner(owner)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int phase = 0;

  // Reference model: owner id (0 idle, 1 video, 2 tm, 3 ts, 4 cpu)
  int          m_owner = 0;
  int          m_pre = 0;
  int          m_cnt = 0;
  logic        m_req = 1'b0;
  logic [20:0] m_addr = '0;

  // Snapshot of DUT outputs in the last stepped cycle
  int          s_owner;
  logic        s_req;
  logic [20:0] s_addr;
  logic [3:0]  s_pre, s_next;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [3:0] onehot(input int id);
    logic [3:0] v;
    v = 4'b0000;
    if (id >= 1 && id <= 4) v[4 - id] = 1'b1;
    return v;
  endfunction

  function automatic logic [20:0] addr_of(input int id);
    case (id)
      1: return video_addr;
      2: return tm_addr;
      3: return ts_addr;
      4: return cpu_addr;
      default: return 21'd0;
    endcase
  endfunction

  // Highest-ranked requester for the current inputs
  function automatic int pick();
    int   order[4];
    logic r[5];
    r[0] = 1'b0; r[1] = video_go; r[2] = tm_req; r[3] = ts_req; r[4] = cpu_req;
    if (video_go) return 1;
`ifdef VIDEO_TS_STARVE_GUARD_EN
    if (ts_req && m_cnt == 7) return 3;
`endif
    if (ts_z80_lp) order = '{1, 2, 3, 4};
    else           order = '{1, 2, 4, 3};
    foreach (order[i]) if (r[order[i]]) return order[i];
    return 0;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_pre = 0; m_cnt = 0; m_req = 1'b0; m_addr = '0;
  endtask

  task automatic model_update();
    int w;
    if (!res_n) begin
      model_reset();
    end else begin
      m_pre = 0;
      if (c3) begin
        w = pick();
        if (!ts_req || w == 3) m_cnt = 0;
        else if (m_cnt < 7) m_cnt++;
        m_owner = w;
        m_req   = (w != 0);
        m_addr  = addr_of(w);
        m_pre   = w;
      end
    end
  endtask

  // One clock: drive c3 at the falling edge, sample and compare, then advance model
  task automatic step(input string tag);
    @(negedge clk);
    c3 = (phase == 0);
    phase = (phase + 1) % 4;
    if (!res_n) model_reset();
    #1;
    s_owner = int'(owner);
    s_req   = dram_req;
    s_addr  = dram_addr;
    s_pre   = {video_pre_next, tm_pre_next, ts_pre_next, cpu_pre_next};
    s_next  = {video_next, tm_next, ts_next, cpu_next};
    chk({tag, ".owner"}, 32'(s_owner), 32'(m_owner));
    chk({tag, ".dram_req"}, 32'(s_req), 32'(m_req));
    chk({tag, ".dram_addr"}, 32'(s_addr), 32'(m_addr));
    chk({tag, ".pre_next"}, 32'(s_pre), 32'(onehot(m_pre)));
    chk({tag, ".next"}, 32'(s_next), 32'(c3 ? onehot(m_owner) : 4'b0000));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic align();
    while (phase != 0) step("align");
  endtask

  task automatic clear_reqs();
    video_go = 1'b0; tm_req = 1'b0; ts_req = 1'b0; cpu_req = 1'b0;
  endtask

  typedef struct {
    logic        vg, tm, ts, cpu, lp;
    int          exp_owner;
    logic [20:0] exp_addr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int exp_o;
    tbl[0] = '{1, 1, 0, 0, 0, 1, 21'h00100};
    tbl[1] = '{0, 1, 1, 1, 0, 2, 21'h0A5A5};
    tbl[2] = '{0, 0, 1, 1, 0, 4, 21'h15555};
    tbl[3] = '{0, 0, 1, 1, 1, 3, 21'h1F000};
    tbl[4] = '{0, 0, 1, 0, 0, 3, 21'h1F000};
    tbl[5] = '{0, 0, 0, 1, 1, 4, 21'h15555};
    tbl[6] = '{0, 0, 0, 0, 1, 0, 21'h00000};
    tbl[7] = '{1, 1, 1, 1, 1, 1, 21'h00100};

    video_addr = 21'h00100; tm_addr = 21'h0A5A5;
    ts_addr = 21'h1F000; cpu_addr = 21'h15555;

    // Reset state
    step("rst");
    step("rst");
    chk("rst.owner", 32'(s_owner), 32'd0);
    chk("rst.dram_req", 32'(s_req), 32'd0);
    chk("rst.dram_addr", 32'(s_addr), 32'd0);
    res_n = 1'b1;
    align();

    // Priority vector table
    foreach (tbl[i]) begin
      align();
      video_go = tbl[i].vg; tm_req = tbl[i].tm; ts_req = tbl[i].ts;
      cpu_req = tbl[i].cpu; ts_z80_lp = tbl[i].lp;
      step("tbl.dec");
      clear_reqs();
      step("tbl.slot");
      chk($sformatf("tbl%0d.owner", i), 32'(s_owner), 32'(tbl[i].exp_owner));
      chk($sformatf("tbl%0d.addr", i), 32'(s_addr), 32'(tbl[i].exp_addr));
      chk($sformatf("tbl%0d.pre", i), 32'(s_pre), 32'(onehot(tbl[i].exp_owner)));
    end

    // Video beats tm, tm takes the following slot back-to-back
    align();
    video_go = 1'b1; tm_req = 1'b1;
    step("vt.dec");
    video_go = 1'b0;
    step("vt.b");
    chk("vt.owner", 32'(s_owner), 32'd1);
    chk("vt.addr", 32'(s_addr), 32'h00100);
    chk("vt.vpre", 32'(s_pre), 32'b1000);
    step("vt.c");
    step("vt.d");
    step("vt.end");
    tm_req = 1'b0;
    chk("vt.vnext", 32'(s_next), 32'b1000);
    step("vt.f");
    chk("vt.tm_owner", 32'(s_owner), 32'd2);
    chk("vt.tm_pre", 32'(s_pre), 32'b0100);

    // tm drops its request mid-slot; slot still completes, then idle
    align();
    tm_req = 1'b1;
    step("drop.dec");
    step("drop.b");
    step("drop.c");
    tm_req = 1'b0;
    step("drop.d");
    chk("drop.addr_hold", 32'(dram_addr), 32'h0A5A5);
    step("drop.end");
    chk("drop.tm_next", 32'(s_next), 32'b0100);
    step("drop.f");
    chk("drop.idle_owner", 32'(s_owner), 32'd0);
    chk("drop.idle_req", 32'(s_req), 32'd0);

    // Reset mid-slot abandons the slot without a data-valid pulse
    align();
    video_go = 1'b1;
    step("mrst.dec");
    step("mrst.b");
    res_n = 1'b0;
    step("mrst.c");
    chk("mrst.owner", 32'(s_owner), 32'd0);
    chk("mrst.req", 32'(s_req), 32'd0);
    chk("mrst.addr", 32'(s_addr), 32'd0);
    res_n = 1'b1;
    step("mrst.d");
    step("mrst.end");
    chk("mrst.no_next", 32'(s_next), 32'b0000);
    video_go = 1'b0;
    step("mrst.f");
    chk("mrst.rearb", 32'(s_owner), 32'd1);

    // tm and ts held for 8 decisions
    align();
    step("starve.pre");
    align();
    tm_req = 1'b1; ts_req = 1'b1; ts_z80_lp = 1'b1;
    for (int d = 1; d <= 8; d++) begin
      step("starve.dec");
      step("starve.b");
`ifdef VIDEO_TS_STARVE_GUARD_EN
      exp_o = (d == 8) ? 3 : 2;
`else
      exp_o = 2;
`endif
      chk($sformatf("starve%0d.owner", d), 32'(s_owner), 32'(exp_o));
      step("starve.c");
      step("starve.d");
    end
    clear_reqs();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      video_go   = ($urandom_range(0, 3) == 0);
      tm_req     = ($urandom_range(0, 2) == 0);
      ts_req     = 1'($urandom_range(0, 1));
      cpu_req    = 1'($urandom_range(0, 1));
      ts_z80_lp  = 1'($urandom_range(0, 1));
      video_addr = 21'($urandom);
      tm_addr    = 21'($urandom);
      ts_addr    = 21'($urandom);
      cpu_addr   = 21'($urandom);
      res_n      = ($urandom_range(0, 99) != 0);
      step("rand");
    end
    res_n = 1'b1;
    clear_reqs();
    step("tail");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
